// File: rtl/enemy_pool_manager_if.sv
// Pixel/draw/command bundle between the video side and the enemy pool manager.
// Latency: n/a (wiring only); no backpressure, every signal is sampled each cycle.
interface enemy_pool_manager_if #(
    parameter int NUM_ENEMIES = 4,
    parameter int ID_WIDTH    = 4
);
    logic                       startOfFrame;
    logic [10:0]                pixelX;
    logic [10:0]                pixelY;
    logic [NUM_ENEMIES*11-1:0]  enemiesTLX;
    logic [NUM_ENEMIES*11-1:0]  enemiesTLY;
    logic                       changeDir;
    logic                       dodgeBullet;
    logic                       shotCollision;
    logic                       pause;
    logic                       newLevel;
    logic [10:0]                offsetX;
    logic [10:0]                offsetY;
    logic                       enemyDrawReq;
    logic                       explosionDrawReq;
    logic                       headsUpDrawReq;
    logic                       headsDownDrawReq;
    logic [ID_WIDTH-1:0]        drawingRequestorId;
    logic [NUM_ENEMIES-1:0]     slotChangeDir;
    logic [NUM_ENEMIES-1:0]     slotDodge;
    logic [NUM_ENEMIES-1:0]     slotHit;
    logic [NUM_ENEMIES-1:0]     slotAlive;
    logic [NUM_ENEMIES-1:0]     slotRestart;
    logic [4:0]                 aliveCount;
    logic                       levelClear;

    modport master (
        output startOfFrame, pixelX, pixelY, enemiesTLX, enemiesTLY,
               changeDir, dodgeBullet, shotCollision, pause, newLevel,
        input  offsetX, offsetY, enemyDrawReq, explosionDrawReq, headsUpDrawReq,
               headsDownDrawReq, drawingRequestorId, slotChangeDir, slotDodge,
               slotHit, slotAlive, slotRestart, aliveCount, levelClear
    );

    modport slave (
        input  startOfFrame, pixelX, pixelY, enemiesTLX, enemiesTLY,
               changeDir, dodgeBullet, shotCollision, pause, newLevel,
        output offsetX, offsetY, enemyDrawReq, explosionDrawReq, headsUpDrawReq,
               headsDownDrawReq, drawingRequestorId, slotChangeDir, slotDodge,
               slotHit, slotAlive, slotRestart, aliveCount, levelClear
    );
endinterface

// File: rtl/enemy_pool_manager.sv
// Enemy pool: per-pixel zone arbitration, command routing and per-slot life-cycle FSMs.
// Latency: draw outputs 1 cycle after pixel, commands 1 cycle after draw outputs; no backpressure.
module enemy_pool_manager #(
    parameter int NUM_ENEMIES       = 4,
    parameter int ID_WIDTH          = 4,
    parameter int ENEMY_WIDTH       = 20,
    parameter int ENEMY_HEIGHT      = 20,
    parameter int HEADS_UP_HEIGHT   = 80,
    parameter int HEADS_DOWN_HEIGHT = 80,
    parameter int SIDE_MARGIN       = 8,
    parameter int INITIAL_ALIVE     = NUM_ENEMIES,
    parameter int DYING_FRAMES      = 16,
    parameter int RESPAWN_FRAMES    = 0
) (
    input logic                 clk,
    input logic                 resetN,
    enemy_pool_manager_if.slave bus
);
    typedef enum logic [1:0] {ST_ALIVE, ST_DYING, ST_DEAD, ST_RESPAWN} state_t;

    localparam int MAX_FRAMES = (DYING_FRAMES > RESPAWN_FRAMES) ? DYING_FRAMES : RESPAWN_FRAMES;
    localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
    localparam logic [CNT_W-1:0] DYING_LOAD = CNT_W'(DYING_FRAMES - 1);
    localparam logic [CNT_W-1:0] RESP_LOAD  = CNT_W'((RESPAWN_FRAMES > 0) ? RESPAWN_FRAMES - 1 : 0);
    localparam logic [11:0] W12  = 12'(ENEMY_WIDTH);
    localparam logic [11:0] H12  = 12'(ENEMY_HEIGHT);
    localparam logic [11:0] HU12 = 12'(HEADS_UP_HEIGHT);
    localparam logic [11:0] HD12 = 12'(HEADS_DOWN_HEIGHT);
    localparam logic [11:0] MUP  = 12'(SIDE_MARGIN);
    localparam logic [11:0] MDN  = 12'(SIDE_MARGIN + 3);

    state_t                 state [NUM_ENEMIES];
    logic [CNT_W-1:0]       cnt   [NUM_ENEMIES];
    logic [NUM_ENEMIES-1:0] in_body, in_hu, in_hd;
    logic [11:0]            px, py;

    assign px = {1'b0, bus.pixelX};
    assign py = {1'b0, bus.pixelY};

    function automatic logic [11:0] lo_clamp(input logic [11:0] a, input logic [11:0] b);
        return (a >= b) ? a - b : 12'd0;
    endfunction

    for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_zone
        logic [11:0] tlx, tly;
        assign tlx = {1'b0, bus.enemiesTLX[11*g +: 11]};
        assign tly = {1'b0, bus.enemiesTLY[11*g +: 11]};
        assign in_body[g] = (px >= tlx) && (px < tlx + W12) && (py >= tly) && (py < tly + H12);
        assign in_hu[g]   = (px >= lo_clamp(tlx, MUP)) && (px < tlx + W12 + MUP) &&
                            (py >= lo_clamp(tly, HU12)) && (py < tly);
        assign in_hd[g]   = (px >= lo_clamp(tlx, MDN)) && (px < tlx + W12 + MDN) &&
                            (py >= tly + H12) && (py < tly + H12 + HD12);
    end

    logic                win_body, win_expl, win_hu, win_hd;
    logic [ID_WIDTH-1:0] id_body, id_expl, id_hu, id_hd, nxt_id;
    logic [10:0]         ox_body, oy_body, ox_expl, oy_expl, nxt_ox, nxt_oy;

    // Descending scan so the lowest index of each class is the last one written.
    always_comb begin
        win_body = 1'b0; win_expl = 1'b0; win_hu = 1'b0; win_hd = 1'b0;
        id_body = '0; id_expl = '0; id_hu = '0; id_hd = '0;
        ox_body = '0; oy_body = '0; ox_expl = '0; oy_expl = '0;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
            if (in_body[i] && state[i] == ST_ALIVE) begin
                win_body = 1'b1; id_body = ID_WIDTH'(i);
                ox_body = bus.pixelX - bus.enemiesTLX[11*i +: 11];
                oy_body = bus.pixelY - bus.enemiesTLY[11*i +: 11];
            end
            if (in_body[i] && state[i] == ST_DYING) begin
                win_expl = 1'b1; id_expl = ID_WIDTH'(i);
                ox_expl = bus.pixelX - bus.enemiesTLX[11*i +: 11];
                oy_expl = bus.pixelY - bus.enemiesTLY[11*i +: 11];
            end
            if (in_hu[i] && state[i] == ST_ALIVE) begin win_hu = 1'b1; id_hu = ID_WIDTH'(i); end
            if (in_hd[i] && state[i] == ST_ALIVE) begin win_hd = 1'b1; id_hd = ID_WIDTH'(i); end
        end
        nxt_id = '0; nxt_ox = '0; nxt_oy = '0;
        if (win_body) begin
            nxt_id = id_body; nxt_ox = ox_body; nxt_oy = oy_body;
        end else if (win_expl) begin
            nxt_id = id_expl; nxt_ox = ox_expl; nxt_oy = oy_expl;
        end else if (win_hu) begin
            nxt_id = id_hu;
        end else if (win_hd) begin
            nxt_id = id_hd;
        end
    end

    logic                   any_req;
    logic [NUM_ENEMIES-1:0] req_onehot;
    assign any_req    = bus.enemyDrawReq | bus.explosionDrawReq | bus.headsUpDrawReq | bus.headsDownDrawReq;
    assign req_onehot = NUM_ENEMIES'(1) << bus.drawingRequestorId;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bus.enemyDrawReq       <= 1'b0;
            bus.explosionDrawReq   <= 1'b0;
            bus.headsUpDrawReq     <= 1'b0;
            bus.headsDownDrawReq   <= 1'b0;
            bus.drawingRequestorId <= '0;
            bus.offsetX            <= '0;
            bus.offsetY            <= '0;
            bus.slotChangeDir      <= '0;
            bus.slotDodge          <= '0;
            bus.slotHit            <= '0;
        end else begin
            bus.enemyDrawReq       <= win_body;
            bus.explosionDrawReq   <= !win_body && win_expl;
            bus.headsUpDrawReq     <= !win_body && !win_expl && win_hu;
            bus.headsDownDrawReq   <= !win_body && !win_expl && !win_hu && win_hd;
            bus.drawingRequestorId <= nxt_id;
            bus.offsetX            <= nxt_ox;
            bus.offsetY            <= nxt_oy;
            bus.slotChangeDir      <= (bus.changeDir && any_req) ? req_onehot : '0;
            bus.slotDodge          <= (bus.dodgeBullet && (bus.headsUpDrawReq || bus.headsDownDrawReq))
                                      ? req_onehot : '0;
            bus.slotHit            <= (bus.shotCollision && bus.enemyDrawReq && !bus.pause && !bus.newLevel)
                                      ? req_onehot : '0;
        end
    end

    logic tick;
    assign tick = bus.startOfFrame && !bus.pause;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                state[i] <= (i < INITIAL_ALIVE) ? ST_ALIVE : ST_DEAD;
                cnt[i]   <= '0;
            end
            bus.slotRestart <= '0;
        end else begin
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                bus.slotRestart[i] <= 1'b0;
                if (bus.newLevel) begin
                    state[i]           <= ST_ALIVE;
                    cnt[i]             <= '0;
                    bus.slotRestart[i] <= 1'b1;
                end else begin
                    case (state[i])
                        ST_ALIVE: if (bus.slotHit[i] && !bus.pause) begin
                            state[i] <= ST_DYING;
                            cnt[i]   <= DYING_LOAD;
                        end
                        ST_DYING: if (tick) begin
                            if (cnt[i] == '0) state[i] <= ST_DEAD;
                            else              cnt[i]   <= cnt[i] - 1'b1;
                        end
                        ST_DEAD: if (RESPAWN_FRAMES > 0) begin
                            state[i] <= ST_RESPAWN;
                            cnt[i]   <= RESP_LOAD;
                        end
                        ST_RESPAWN: if (tick) begin
                            if (cnt[i] == '0) begin
                                state[i]           <= ST_ALIVE;
                                bus.slotRestart[i] <= 1'b1;
                            end else begin
                                cnt[i] <= cnt[i] - 1'b1;
                            end
                        end
                        default: state[i] <= ST_DEAD;
                    endcase
                end
            end
        end
    end

    logic [4:0] n_alive;
    logic       all_dead, all_dead_q;

    always_comb begin
        n_alive       = '0;
        all_dead      = 1'b1;
        bus.slotAlive = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            bus.slotAlive[i] = (state[i] == ST_ALIVE);
            n_alive          = n_alive + {4'd0, (state[i] == ST_ALIVE)};
            all_dead         = all_dead && (state[i] == ST_DEAD);
        end
    end

    // Rising edge of "all dead" so the pulse cannot repeat while the pool stays dead.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bus.aliveCount <= 5'(INITIAL_ALIVE);
            bus.levelClear <= 1'b0;
            all_dead_q     <= (INITIAL_ALIVE == 0);
        end else begin
            bus.aliveCount <= n_alive;
            bus.levelClear <= all_dead && !all_dead_q;
            all_dead_q     <= all_dead;
        end
    end
endmodule

// File: tb/tb_enemy_pool_manager.sv
// Directed bench: one DUT without respawn, one with RESPAWN_FRAMES=3, sharing all inputs.
module tb_enemy_pool_manager;
    logic       clk = 1'b0;
    logic       resetN;
    int         checks = 0;
    int         failures = 0;
    int         lc_pulses = 0;
    logic [3:0] restart_acc = '0;

    always #5 clk = ~clk;

    enemy_pool_manager_if #(.NUM_ENEMIES(4), .ID_WIDTH(4)) bus ();
    enemy_pool_manager_if #(.NUM_ENEMIES(4), .ID_WIDTH(4)) bus_r ();

    assign bus_r.startOfFrame  = bus.startOfFrame;
    assign bus_r.pixelX        = bus.pixelX;
    assign bus_r.pixelY        = bus.pixelY;
    assign bus_r.enemiesTLX    = bus.enemiesTLX;
    assign bus_r.enemiesTLY    = bus.enemiesTLY;
    assign bus_r.changeDir     = bus.changeDir;
    assign bus_r.dodgeBullet   = bus.dodgeBullet;
    assign bus_r.shotCollision = bus.shotCollision;
    assign bus_r.pause         = bus.pause;
    assign bus_r.newLevel      = bus.newLevel;

    enemy_pool_manager #(.NUM_ENEMIES(4), .ID_WIDTH(4)) u_dut (
        .clk(clk), .resetN(resetN), .bus(bus));
    enemy_pool_manager #(.NUM_ENEMIES(4), .ID_WIDTH(4), .RESPAWN_FRAMES(3)) u_dut_r (
        .clk(clk), .resetN(resetN), .bus(bus_r));

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.levelClear) lc_pulses++;
        restart_acc |= bus_r.slotRestart;
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        step();
        bus.startOfFrame = 1'b0;
        step();
    endtask

    task automatic set_pos(input int s, input int x, input int y);
        bus.enemiesTLX[11*s +: 11] = 11'(x);
        bus.enemiesTLY[11*s +: 11] = 11'(y);
    endtask

    task automatic set_pix(input int x, input int y);
        bus.pixelX = 11'(x);
        bus.pixelY = 11'(y);
    endtask

    // Registers a body hit at (x,y); hit returns the slotHit pulse seen on the command cycle.
    task automatic shoot(input int x, input int y, output logic [3:0] hit);
        set_pix(x, y);
        step();
        bus.shotCollision = 1'b1;
        step();
        hit = bus.slotHit;
        bus.shotCollision = 1'b0;
        step();
    endtask

    task automatic test_reset();
        step();
        checks++; if ({bus.enemyDrawReq, bus.explosionDrawReq, bus.headsUpDrawReq, bus.headsDownDrawReq} !== 4'b0000) begin
            failures++; $display("FAIL reset_draw got=%b want=0000", {bus.enemyDrawReq, bus.explosionDrawReq, bus.headsUpDrawReq, bus.headsDownDrawReq}); end
        checks++; if ({bus.offsetX, bus.offsetY, bus.drawingRequestorId} !== 26'd0) begin
            failures++; $display("FAIL reset_offs_id got=%h want=0", {bus.offsetX, bus.offsetY, bus.drawingRequestorId}); end
        checks++; if ({bus.aliveCount, bus.slotAlive} !== {5'd4, 4'b1111}) begin
            failures++; $display("FAIL reset_alive got=%h want=%h", {bus.aliveCount, bus.slotAlive}, {5'd4, 4'b1111}); end
        checks++; if ({bus.slotHit, bus.slotRestart, bus.slotChangeDir, bus.slotDodge, bus.levelClear} !== 17'd0) begin
            failures++; $display("FAIL reset_pulses got=%h want=0", {bus.slotHit, bus.slotRestart, bus.slotChangeDir, bus.slotDodge, bus.levelClear}); end
        resetN = 1'b1;
        step();
    endtask

    task automatic test_body();
        set_pix(105, 110);
        step();
        checks++; if ({bus.enemyDrawReq, bus.explosionDrawReq, bus.headsUpDrawReq, bus.headsDownDrawReq, bus.drawingRequestorId} !== 8'b1000_0000) begin
            failures++; $display("FAIL body_req got=%b want=10000000", {bus.enemyDrawReq, bus.explosionDrawReq, bus.headsUpDrawReq, bus.headsDownDrawReq, bus.drawingRequestorId}); end
        checks++; if ({bus.offsetX, bus.offsetY} !== {11'd5, 11'd10}) begin
            failures++; $display("FAIL body_offs got=%0d,%0d want=5,10", bus.offsetX, bus.offsetY); end
    endtask

    task automatic test_heads();
        logic [4:0] draws_id [5];
        logic [4:0] want     [5];
        set_pix(210, 150); step(); draws_id[0] = {bus.enemyDrawReq, bus.explosionDrawReq, bus.headsUpDrawReq, bus.headsDownDrawReq, bus.drawingRequestorId[0]};
        set_pix(198, 230); step(); draws_id[1] = {bus.enemyDrawReq, bus.explosionDrawReq, bus.headsUpDrawReq, bus.headsDownDrawReq, bus.drawingRequestorId[0]};
        set_pix(219, 219); step(); draws_id[2] = {bus.enemyDrawReq, bus.explosionDrawReq, bus.headsUpDrawReq, bus.headsDownDrawReq, bus.drawingRequestorId[0]};
        checks++; if ({bus.offsetX, bus.offsetY} !== {11'd19, 11'd19}) begin
            failures++; $display("FAIL body_edge_offs got=%0d,%0d want=19,19", bus.offsetX, bus.offsetY); end
        set_pix(220, 200); step(); draws_id[3] = {bus.enemyDrawReq, bus.explosionDrawReq, bus.headsUpDrawReq, bus.headsDownDrawReq, bus.drawingRequestorId[0]};
        set_pos(3, 3, 5);
        set_pix(0, 0); step(); draws_id[4] = {bus.enemyDrawReq, bus.explosionDrawReq, bus.headsUpDrawReq, bus.headsDownDrawReq, bus.drawingRequestorId[0]};
        checks++; if (bus.drawingRequestorId !== 4'd3) begin
            failures++; $display("FAIL clamp_id got=%0d want=3", bus.drawingRequestorId); end
        set_pos(3, 400, 400);
        want[0] = 5'b0010_1; want[1] = 5'b0001_1; want[2] = 5'b1000_1; want[3] = 5'b0000_0; want[4] = 5'b0010_1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (draws_id[k] !== want[k]) begin
                failures++; $display("FAIL heads_vec%0d got=%b want=%b", k, draws_id[k], want[k]); end
        end
    endtask

    task automatic test_commands();
        set_pix(210, 150);
        step();
        bus.changeDir = 1'b1; bus.dodgeBullet = 1'b1;
        step();
        checks++; if ({bus.slotChangeDir, bus.slotDodge} !== 8'b0010_0010) begin
            failures++; $display("FAIL cmd_heads got=%b want=00100010", {bus.slotChangeDir, bus.slotDodge}); end
        set_pix(105, 110);
        step();
        step();
        checks++; if ({bus.slotChangeDir, bus.slotDodge} !== 8'b0001_0000) begin
            failures++; $display("FAIL cmd_body got=%b want=00010000", {bus.slotChangeDir, bus.slotDodge}); end
        bus.changeDir = 1'b0; bus.dodgeBullet = 1'b0;
        step();
    endtask

    task automatic test_hit();
        logic [3:0] hit;
        set_pos(2, 300, 300);
        shoot(305, 305, hit);
        checks++; if (hit !== 4'b0100) begin
            failures++; $display("FAIL hit_slot2 got=%b want=0100", hit); end
        checks++; if ({bus.slotHit, bus.slotAlive, bus.aliveCount} !== {4'b0000, 4'b1011, 5'd4}) begin
            failures++; $display("FAIL hit_after got=%h want=%h", {bus.slotHit, bus.slotAlive, bus.aliveCount}, {4'b0000, 4'b1011, 5'd4}); end
        step();
        checks++; if ({bus.explosionDrawReq, bus.enemyDrawReq, bus.drawingRequestorId, bus.aliveCount} !== {2'b10, 4'd2, 5'd3}) begin
            failures++; $display("FAIL expl_start got=%h want=%h", {bus.explosionDrawReq, bus.enemyDrawReq, bus.drawingRequestorId, bus.aliveCount}, {2'b10, 4'd2, 5'd3}); end
        repeat (15) frame();
        checks++; if (bus.explosionDrawReq !== 1'b1) begin
            failures++; $display("FAIL expl_15 got=%b want=1", bus.explosionDrawReq); end
        frame();
        checks++; if ({bus.enemyDrawReq, bus.explosionDrawReq, bus.headsUpDrawReq, bus.headsDownDrawReq, bus.offsetX} !== 15'd0) begin
            failures++; $display("FAIL expl_end got=%h want=0", {bus.enemyDrawReq, bus.explosionDrawReq, bus.headsUpDrawReq, bus.headsDownDrawReq, bus.offsetX}); end
    endtask

    task automatic test_level_clear();
        logic [3:0] h0, h1, h3;
        lc_pulses = 0;
        shoot(105, 110, h0);
        shoot(205, 205, h1);
        shoot(405, 405, h3);
        checks++; if ({h0, h1, h3} !== 12'b0001_0010_1000) begin
            failures++; $display("FAIL kill_hits got=%b want=000100101000", {h0, h1, h3}); end
        set_pix(1500, 1000);
        repeat (20) frame();
        checks++; if (lc_pulses !== 1 || bus.aliveCount !== 5'd0) begin
            failures++; $display("FAIL level_clear got=%0d,%0d want=1,0", lc_pulses, bus.aliveCount); end
        bus.newLevel = 1'b1;
        step();
        bus.newLevel = 1'b0;
        checks++; if ({bus.slotRestart, bus.slotAlive} !== 8'b1111_1111) begin
            failures++; $display("FAIL newlevel_restart got=%b want=11111111", {bus.slotRestart, bus.slotAlive}); end
        step();
        checks++; if ({bus.slotRestart, bus.aliveCount} !== {4'b0000, 5'd4}) begin
            failures++; $display("FAIL newlevel_count got=%h want=%h", {bus.slotRestart, bus.aliveCount}, {4'b0000, 5'd4}); end
    endtask

    task automatic test_respawn_pause();
        logic [3:0] h;
        shoot(105, 110, h);
        checks++; if (bus_r.slotAlive !== 4'b1110) begin
            failures++; $display("FAIL resp_kill got=%b want=1110", bus_r.slotAlive); end
        restart_acc = '0;
        repeat (4) frame();
        bus.pause = 1'b1;
        repeat (5) frame();
        bus.pause = 1'b0;
        repeat (11) frame();
        checks++; if ({bus_r.enemyDrawReq, bus_r.explosionDrawReq, bus_r.drawingRequestorId} !== 6'b01_0000) begin
            failures++; $display("FAIL resp_dying15 got=%b want=010000", {bus_r.enemyDrawReq, bus_r.explosionDrawReq, bus_r.drawingRequestorId}); end
        frame();
        checks++; if ({bus_r.enemyDrawReq, bus_r.explosionDrawReq} !== 2'b00) begin
            failures++; $display("FAIL resp_dead got=%b want=00", {bus_r.enemyDrawReq, bus_r.explosionDrawReq}); end
        frame();
        frame();
        checks++; if (restart_acc !== 4'b0000) begin
            failures++; $display("FAIL resp_early got=%b want=0000", restart_acc); end
        bus.startOfFrame = 1'b1;
        step();
        bus.startOfFrame = 1'b0;
        checks++; if (bus_r.slotRestart !== 4'b0001) begin
            failures++; $display("FAIL resp_restart got=%b want=0001", bus_r.slotRestart); end
        step();
        checks++; if ({bus_r.slotRestart, bus_r.slotAlive, bus_r.enemyDrawReq} !== 9'b0000_1111_1) begin
            failures++; $display("FAIL resp_alive got=%b want=000011111", {bus_r.slotRestart, bus_r.slotAlive, bus_r.enemyDrawReq}); end
    endtask

    task automatic test_newlevel_hit();
        set_pix(405, 405);
        step();
        bus.shotCollision = 1'b1; bus.newLevel = 1'b1;
        step();
        bus.shotCollision = 1'b0; bus.newLevel = 1'b0;
        checks++; if ({bus.slotHit, bus.slotRestart} !== 8'b0000_1111) begin
            failures++; $display("FAIL nl_hit got=%b want=00001111", {bus.slotHit, bus.slotRestart}); end
        step();
        step();
        checks++; if ({bus.slotAlive, bus.aliveCount} !== {4'b1111, 5'd4}) begin
            failures++; $display("FAIL nl_alive got=%h want=%h", {bus.slotAlive, bus.aliveCount}, {4'b1111, 5'd4}); end
        bus.shotCollision = 1'b1; bus.pause = 1'b1;
        step();
        bus.shotCollision = 1'b0; bus.pause = 1'b0;
        checks++; if (bus.slotHit !== 4'b0000) begin
            failures++; $display("FAIL pause_hit got=%b want=0000", bus.slotHit); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [3:0] h;
        shoot(405, 405, h);
        frame();
        frame();
        checks++; if ({bus.explosionDrawReq, bus.drawingRequestorId, bus.offsetX, bus.offsetY} !== {1'b1, 4'd3, 11'd5, 11'd5}) begin
            failures++; $display("FAIL mid_expl got=%h want=%h", {bus.explosionDrawReq, bus.drawingRequestorId, bus.offsetX, bus.offsetY}, {1'b1, 4'd3, 11'd5, 11'd5}); end
        #2 resetN = 1'b0;
        #1;
        checks++; if ({bus.enemyDrawReq, bus.explosionDrawReq, bus.drawingRequestorId, bus.offsetX, bus.offsetY} !== 28'd0) begin
            failures++; $display("FAIL mid_reset_draw got=%h want=0", {bus.enemyDrawReq, bus.explosionDrawReq, bus.drawingRequestorId, bus.offsetX, bus.offsetY}); end
        checks++; if ({bus.slotAlive, bus.aliveCount, bus.slotHit, bus.levelClear} !== {4'b1111, 5'd4, 4'b0000, 1'b0}) begin
            failures++; $display("FAIL mid_reset_state got=%h want=%h", {bus.slotAlive, bus.aliveCount, bus.slotHit, bus.levelClear}, {4'b1111, 5'd4, 4'b0000, 1'b0}); end
        step();
        resetN = 1'b1;
        step();
    endtask

    initial begin
        resetN = 1'b0;
        bus.startOfFrame = 1'b0; bus.changeDir = 1'b0; bus.dodgeBullet = 1'b0;
        bus.shotCollision = 1'b0; bus.pause = 1'b0; bus.newLevel = 1'b0;
        bus.enemiesTLX = '0; bus.enemiesTLY = '0;
        set_pos(0, 100, 100);
        set_pos(1, 200, 200);
        set_pos(2, 200, 200);
        set_pos(3, 400, 400);
        set_pix(1500, 1000);
        test_reset();
        test_body();
        test_heads();
        test_commands();
        test_hit();
        test_level_clear();
        test_respawn_pause();
        test_newlevel_hit();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
